// File: rtl/mul_div_sequencer.sv
// Control sequencer for the multiply/divide instruction path.
// Runs a fetch (T0..T2) followed by the MUL/DIV execute steps (T3..T6),
// holding each step for HOLD cycles and stretching T1 until memory is ready.
// All outputs are a pure decode of the registered state and latched fields.
module mul_div_sequencer #(
  parameter int                NUM_REGS = 16,
  parameter int                OPC_W    = 5,
  parameter int                HOLD     = 1,
  parameter logic [OPC_W-1:0]  MUL_OPC  = 5'b01111,
  parameter logic [OPC_W-1:0]  DIV_OPC  = 5'b10000
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OPC_W-1:0]    alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE, S_ILL
  } state_t;

  // Last value of the step counter within one step.
  localparam logic [3:0] LAST = 4'(HOLD - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [OPC_W-1:0] r_op;
  logic [3:0]       r_ra;
  logic [3:0]       r_rb;

  state_t           w_nxt;
  logic             w_step_end;
  logic [OPC_W-1:0] w_op;
  logic [3:0]       w_ra;
  logic [3:0]       w_rb;
  logic             w_legal;
  logic [3:0]       w_sel;
  logic             w_sel_en;

  assign w_step_end = (r_cnt == LAST);
  assign w_op       = OPC_W'(ir[31:27]);
  assign w_ra       = ir[26:23];
  assign w_rb       = ir[22:19];

  // Decode legality from the live ir; it is evaluated on the same edge the
  // fields are latched, so the decision and the latched copy always agree.
  assign w_legal = ((w_op == MUL_OPC) || (w_op == DIV_OPC)) &&
                   (int'(w_ra) < NUM_REGS) && (int'(w_rb) < NUM_REGS);

  // Next-state selection: each timed step leaves only when its HOLD window
  // has elapsed; T1 additionally waits indefinitely for mem_ready.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (start)                   w_nxt = S_T0;
      S_T0:   if (w_step_end)              w_nxt = S_T1;
      S_T1:   if (w_step_end && mem_ready) w_nxt = S_T2;
      S_T2:   if (w_step_end)              w_nxt = w_legal ? S_T3 : S_ILL;
      S_T3:   if (w_step_end)              w_nxt = S_T4;
      S_T4:   if (w_step_end)              w_nxt = S_T5;
      S_T5:   if (w_step_end)              w_nxt = S_T6;
      S_T6:   if (w_step_end)              w_nxt = S_DONE;
      S_DONE:                              w_nxt = S_IDLE;
      S_ILL:                               w_nxt = S_IDLE;
      default:                             w_nxt = S_IDLE;
    endcase
  end

  // State, step counter and instruction-field latch.
  always_ff @(posedge Clock) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
    end else begin
      r_state <= w_nxt;
      // Counter restarts on every state change and saturates at LAST so a
      // long T1 wait cannot wrap it.
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (!w_step_end)
        r_cnt <= r_cnt + 4'd1;
      if ((r_state == S_T2) && w_step_end) begin
        r_op <= w_op;
        r_ra <= w_ra;
        r_rb <= w_rb;
      end
    end
  end

  // Register-out select: ra in T3, rb in T4, nothing otherwise.
  always_comb begin
    w_sel    = '0;
    w_sel_en = 1'b0;
    if (r_state == S_T3) begin
      w_sel    = r_ra;
      w_sel_en = 1'b1;
    end else if (r_state == S_T4) begin
      w_sel    = r_rb;
      w_sel_en = 1'b1;
    end
  end

  // One-hot Rout decode; only one index can match, so at most one bit is set.
  always_comb begin
    Rout = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_sel_en && (int'(w_sel) == i))
        Rout[i] = 1'b1;
  end

  // Moore decode of the datapath controls from the registered state.
  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    alu_op   = '0;
    case (r_state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: Yin = 1'b1;
      S_T4: begin
        Zin    = 1'b1;
        alu_op = r_op;
      end
      S_T5: begin
        Zlowout = 1'b1;
        LOin    = 1'b1;
        alu_op  = r_op;
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        alu_op   = r_op;
      end
      default: ;
    endcase
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign illegal = (r_state == S_ILL);

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer: a per-cycle vector table against a
// HOLD=1 instance, plus hand-written sequences against a HOLD=3 instance.
module tb_mul_div_sequencer;

  localparam logic [13:0] C_T0 = 14'h3C00;  // PCout MARin IncPC Zin
  localparam logic [13:0] C_T1 = 14'h02E0;  // Zlowout PCin Read MDRin
  localparam logic [13:0] C_T2 = 14'h0018;  // MDRout IRin
  localparam logic [13:0] C_T3 = 14'h0004;  // Yin
  localparam logic [13:0] C_T4 = 14'h0400;  // Zin
  localparam logic [13:0] C_T5 = 14'h0202;  // Zlowout LOin
  localparam logic [13:0] C_T6 = 14'h0101;  // Zhighout HIin
  localparam logic [31:0] MUL  = 32'h7918_0000;  // mul R2,R3
  localparam logic [31:0] DIV  = 32'h82A8_0000;  // div R5,R5
  localparam logic [31:0] BAD  = 32'h1800_0000;  // opcode 00011
  localparam logic [2:0]  NO = 3'b000, B = 3'b100, D = 3'b110, I = 3'b101;

  logic        Clock = 1'b0;
  logic        clear = 1'b0;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] ir = 32'h0;

  // ctl bit order: PCout MARin IncPC Zin Zlowout Zhighout PCin Read MDRin
  //                MDRout IRin Yin LOin HIin
  wire [13:0] ctl1, ctl3;
  wire [15:0] rout1, rout3;
  wire [4:0]  alu1, alu3;
  wire        busy1, done1, ill1, busy3, done3, ill3;

  always #5 Clock = ~Clock;

  mul_div_sequencer #(.HOLD(1)) u_h1 (
    .Clock(Clock), .clear(clear), .start(start1), .mem_ready(mem_ready), .ir(ir),
    .PCout(ctl1[13]), .MARin(ctl1[12]), .IncPC(ctl1[11]), .Zin(ctl1[10]),
    .Zlowout(ctl1[9]), .Zhighout(ctl1[8]), .PCin(ctl1[7]), .Read(ctl1[6]),
    .MDRin(ctl1[5]), .MDRout(ctl1[4]), .IRin(ctl1[3]), .Yin(ctl1[2]),
    .LOin(ctl1[1]), .HIin(ctl1[0]), .Rout(rout1), .alu_op(alu1),
    .busy(busy1), .done(done1), .illegal(ill1));

  mul_div_sequencer #(.HOLD(3)) u_h3 (
    .Clock(Clock), .clear(clear), .start(start3), .mem_ready(mem_ready), .ir(ir),
    .PCout(ctl3[13]), .MARin(ctl3[12]), .IncPC(ctl3[11]), .Zin(ctl3[10]),
    .Zlowout(ctl3[9]), .Zhighout(ctl3[8]), .PCin(ctl3[7]), .Read(ctl3[6]),
    .MDRin(ctl3[5]), .MDRout(ctl3[4]), .IRin(ctl3[3]), .Yin(ctl3[2]),
    .LOin(ctl3[1]), .HIin(ctl3[0]), .Rout(rout3), .alu_op(alu3),
    .busy(busy3), .done(done3), .illegal(ill3));

  typedef struct {
    logic        clr;
    logic        st;
    logic        mr;
    logic [31:0] ir;
    logic [37:0] exp;  // {ctl, rout, alu, busy, done, illegal}
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic c, input logic s, input logic m,
                     input logic [31:0] iv, input logic [13:0] ct,
                     input logic [15:0] ro, input logic [4:0] al,
                     input logic [2:0] bdi);
    vec_t v;
    v.clr = c; v.st = s; v.mr = m; v.ir = iv;
    v.exp = {ct, ro, al, bdi};
    tbl.push_back(v);
  endtask

  // T3..DONE then IDLE; the T3 edge latches irt3, later edges see irl.
  task automatic add_tail(input logic s, input logic [31:0] irt3,
                          input logic [31:0] irl, input logic [15:0] ra,
                          input logic [15:0] rb, input logic [4:0] al);
    add(1, s, 1, irt3, C_T3, ra, 5'h0, B);
    add(1, s, 1, irl,  C_T4, rb, al,   B);
    add(1, s, 1, irl,  C_T5, 16'h0, al, B);
    add(1, s, 1, irl,  C_T6, 16'h0, al, B);
    add(1, s, 1, irl,  14'h0, 16'h0, 5'h0, D);
    add(1, s, 1, irl,  14'h0, 16'h0, 5'h0, NO);
  endtask

  task automatic chk(input string nm, input logic [37:0] got, input logic [37:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got ctl=%h rout=%h alu=%h bdi=%b, expected ctl=%h rout=%h alu=%h bdi=%b",
               nm, got[37:24], got[23:8], got[7:3], got[2:0],
               exp[37:24], exp[23:8], exp[7:3], exp[2:0]);
    end
  endtask

  logic [13:0] h3_ctl [7];
  logic [37:0] e3;
  int          s3;

  initial begin
    // Reset together with start: must stay IDLE and forget start.
    add(0, 1, 1, MUL, 14'h0, 16'h0, 5'h0, NO);
    add(1, 0, 1, MUL, 14'h0, 16'h0, 5'h0, NO);
    // mul R2,R3; ir changes after the latch edge must not matter.
    add(1, 1, 1, MUL, C_T0, 16'h0, 5'h0, B);
    add(1, 0, 1, MUL, C_T1, 16'h0, 5'h0, B);
    add(1, 0, 1, MUL, C_T2, 16'h0, 5'h0, B);
    add_tail(0, MUL, 32'h0, 16'h0004, 16'h0008, 5'b01111);
    // div R5,R5 with T1 stretched to 6 cycles.
    add(1, 1, 1, DIV, C_T0, 16'h0, 5'h0, B);
    add(1, 0, 0, DIV, C_T1, 16'h0, 5'h0, B);
    for (int k = 0; k < 5; k++) add(1, 0, 0, DIV, C_T1, 16'h0, 5'h0, B);
    add(1, 0, 1, DIV, C_T2, 16'h0, 5'h0, B);
    add_tail(0, DIV, DIV, 16'h0020, 16'h0020, 5'b10000);
    // Illegal opcode: ILL right after T2, never T3.
    add(1, 1, 1, BAD, C_T0, 16'h0, 5'h0, B);
    add(1, 0, 1, BAD, C_T1, 16'h0, 5'h0, B);
    add(1, 0, 1, BAD, C_T2, 16'h0, 5'h0, B);
    add(1, 0, 1, BAD, 14'h0, 16'h0, 5'h0, I);
    add(1, 0, 1, BAD, 14'h0, 16'h0, 5'h0, NO);
    add(1, 0, 1, BAD, 14'h0, 16'h0, 5'h0, NO);
    // clear during T5, then a full normal run.
    add(1, 1, 1, MUL, C_T0, 16'h0, 5'h0, B);
    add(1, 0, 1, MUL, C_T1, 16'h0, 5'h0, B);
    add(1, 0, 1, MUL, C_T2, 16'h0, 5'h0, B);
    add(1, 0, 1, MUL, C_T3, 16'h0004, 5'h0, B);
    add(1, 0, 1, MUL, C_T4, 16'h0008, 5'b01111, B);
    add(1, 0, 1, MUL, C_T5, 16'h0, 5'b01111, B);
    add(0, 0, 1, MUL, 14'h0, 16'h0, 5'h0, NO);
    add(1, 0, 1, MUL, 14'h0, 16'h0, 5'h0, NO);
    add(1, 1, 1, MUL, C_T0, 16'h0, 5'h0, B);
    add(1, 0, 1, MUL, C_T1, 16'h0, 5'h0, B);
    add(1, 0, 1, MUL, C_T2, 16'h0, 5'h0, B);
    add_tail(0, MUL, MUL, 16'h0004, 16'h0008, 5'b01111);
    // clear during the T1 wait.
    add(1, 1, 0, DIV, C_T0, 16'h0, 5'h0, B);
    add(1, 0, 0, DIV, C_T1, 16'h0, 5'h0, B);
    add(1, 0, 0, DIV, C_T1, 16'h0, 5'h0, B);
    add(0, 0, 0, DIV, 14'h0, 16'h0, 5'h0, NO);
    // start held high: exactly one IDLE between DONE and the next T0.
    add(1, 1, 1, MUL, C_T0, 16'h0, 5'h0, B);
    add(1, 1, 1, MUL, C_T1, 16'h0, 5'h0, B);
    add(1, 1, 1, MUL, C_T2, 16'h0, 5'h0, B);
    add_tail(1, MUL, MUL, 16'h0004, 16'h0008, 5'b01111);
    add(1, 1, 1, MUL, C_T0, 16'h0, 5'h0, B);
    add(0, 0, 1, MUL, 14'h0, 16'h0, 5'h0, NO);

    foreach (tbl[k]) begin
      @(negedge Clock);
      clear = tbl[k].clr; start1 = tbl[k].st;
      mem_ready = tbl[k].mr; ir = tbl[k].ir;
      @(posedge Clock); #1;
      chk($sformatf("h1_vec%0d", k), {ctl1, rout1, alu1, busy1, done1, ill1}, tbl[k].exp);
    end
    @(negedge Clock);
    start1 = 1'b0; clear = 1'b1; mem_ready = 1'b1; ir = DIV;

    // HOLD=3 div R5,R5: 3 cycles per step, done in cycle 22.
    h3_ctl = '{C_T0, C_T1, C_T2, C_T3, C_T4, C_T5, C_T6};
    for (int c = 1; c <= 23; c++) begin
      @(negedge Clock);
      start3 = (c == 1);
      @(posedge Clock); #1;
      if (c <= 21) begin
        s3 = (c - 1) / 3;
        e3 = {h3_ctl[s3], ((s3 == 3) || (s3 == 4)) ? 16'h0020 : 16'h0,
              (s3 >= 4) ? 5'b10000 : 5'h0, B};
      end else if (c == 22) e3 = {14'h0, 16'h0, 5'h0, D};
      else                  e3 = {14'h0, 16'h0, 5'h0, NO};
      chk($sformatf("h3_div_c%0d", c), {ctl3, rout3, alu3, busy3, done3, ill3}, e3);
    end

    // HOLD=3 clear in the middle of a T0 hold window.
    @(negedge Clock); start3 = 1'b1;
    @(negedge Clock); start3 = 1'b0;
    @(posedge Clock); #1;
    chk("h3_t0_hold", {ctl3, rout3, alu3, busy3, done3, ill3}, {C_T0, 16'h0, 5'h0, B});
    @(negedge Clock); clear = 1'b0;
    @(posedge Clock); #1;
    chk("h3_clear_midhold", {ctl3, rout3, alu3, busy3, done3, ill3}, {14'h0, 16'h0, 5'h0, NO});
    @(negedge Clock); clear = 1'b1;
    @(posedge Clock); #1;
    chk("h3_idle_after_clear", {ctl3, rout3, alu3, busy3, done3, ill3}, {14'h0, 16'h0, 5'h0, NO});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
